// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampled UART receiver with held output word
// Optional parity bit checking is built only when UART_RX_PARITY_EN is defined.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rxd,
  input  logic                 d_ack,
  output logic [DATA_BITS-1:0] dout,
  output logic                 d_rdy,
  output logic                 rx_rdy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] HALF_CNT  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_CNT  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               state;
  logic [SW-1:0]        samp_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_err;
  logic                 sync1, sync2;
  logic                 rxd_s;
  logic                 stop_done;

  assign rxd_s = sync2;

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
    end
  end

  assign stop_done = (state == S_STOP) && tick && (samp_cnt == FULL_CNT) &&
                     (bit_cnt == LAST_STOP);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_bad;
  assign par_bad = ((^shreg) ^ par_bit) != ODD;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      stop_err  <= 1'b0;
      dout      <= '0;
      d_rdy     <= 1'b0;
      rx_rdy    <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      // A completing frame wins over an acknowledge in the same cycle.
      if (stop_done) begin
        dout      <= shreg;
        frame_err <= stop_err | ~rxd_s;
        d_rdy     <= 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_err <= par_bad;
`endif
        if (d_rdy && !d_ack)
          overrun <= 1'b1;
      end else if (d_ack) begin
        d_rdy   <= 1'b0;
        overrun <= 1'b0;
      end

      if (tick) begin
        case (state)
          S_IDLE: begin
            if (!rxd_s) begin
              state    <= S_START;
              samp_cnt <= '0;
              rx_rdy   <= 1'b0;
            end
          end
          S_START: begin
            if (samp_cnt == HALF_CNT) begin
              samp_cnt <= '0;
              if (!rxd_s) begin
                state   <= S_DATA;
                bit_cnt <= '0;
              end else begin
                state  <= S_IDLE;
                rx_rdy <= 1'b1;
              end
            end else begin
              samp_cnt <= samp_cnt + SW'(1);
            end
          end
          S_DATA: begin
            if (samp_cnt == FULL_CNT) begin
              samp_cnt <= '0;
              shreg    <= {rxd_s, shreg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_DATA) begin
                bit_cnt  <= '0;
                stop_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                state    <= S_PARITY;
`else
                state    <= S_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              samp_cnt <= samp_cnt + SW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (samp_cnt == FULL_CNT) begin
              samp_cnt <= '0;
              par_bit  <= rxd_s;
              state    <= S_STOP;
            end else begin
              samp_cnt <= samp_cnt + SW'(1);
            end
          end
`endif
          S_STOP: begin
            if (samp_cnt == FULL_CNT) begin
              samp_cnt <= '0;
              if (bit_cnt == LAST_STOP) begin
                // Back to IDLE at once; a low stop line may start the next frame.
                state   <= S_IDLE;
                rx_rdy  <= 1'b1;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
                if (!rxd_s)
                  stop_err <= 1'b1;
              end
            end else begin
              samp_cnt <= samp_cnt + SW'(1);
            end
          end
          default: begin
            state  <= S_IDLE;
            rx_rdy <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
